// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue: circular instruction queue between fetch and decode.
// Accepts up to two instructions per cycle and delivers up to two per cycle,
// in program order. The exception event flushes all contents.
module fetch_inst_queue #(
    parameter int P_DEPTH   = 8,
    parameter int P_DEPTH_N = 3
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 iEXCEPTION_EVENT,
    input  logic                 iPREVIOUS_0_INST_VALID,
    input  logic [5:0]           iPREVIOUS_0_MMU_FLAGS,
    input  logic [31:0]          iPREVIOUS_0_INST,
    input  logic                 iPREVIOUS_1_INST_VALID,
    input  logic [5:0]           iPREVIOUS_1_MMU_FLAGS,
    input  logic [31:0]          iPREVIOUS_1_INST,
    input  logic [31:0]          iPREVIOUS_PC,
    output logic                 oPREVIOUS_LOCK,
    output logic                 oNEXT_0_INST_VALID,
    output logic [5:0]           oNEXT_0_MMU_FLAGS,
    output logic [31:0]          oNEXT_0_INST,
    output logic [31:0]          oNEXT_0_PC,
    output logic                 oNEXT_1_INST_VALID,
    output logic [5:0]           oNEXT_1_MMU_FLAGS,
    output logic [31:0]          oNEXT_1_INST,
    output logic [31:0]          oNEXT_1_PC,
    input  logic                 iNEXT_LOCK,
    output logic [P_DEPTH_N:0]   oCOUNT
);

    localparam logic [P_DEPTH_N:0]   LP_DEPTH = (P_DEPTH_N+1)'(P_DEPTH);
    localparam logic [P_DEPTH_N:0]   LP_TWO_C = (P_DEPTH_N+1)'(2);
    localparam logic [P_DEPTH_N-1:0] LP_ONE_P = P_DEPTH_N'(1);
    localparam logic [P_DEPTH_N-1:0] LP_TWO_P = P_DEPTH_N'(2);

    // Entry storage; data is never reset, occupancy is tracked by r_count.
    logic [31:0]          r_inst  [P_DEPTH];
    logic [5:0]           r_flags [P_DEPTH];
    logic [31:0]          r_pc    [P_DEPTH];

    logic [P_DEPTH_N-1:0] r_wptr;
    logic [P_DEPTH_N-1:0] r_rptr;
    logic [P_DEPTH_N:0]   r_count;

    logic                 w_lock;
    logic                 w_push_en;
    logic [P_DEPTH_N-1:0] w_push_inc;
    logic [P_DEPTH_N-1:0] w_pop_inc;
    logic [P_DEPTH_N-1:0] w_wr1;
    logic [P_DEPTH_N-1:0] w_rd1;
    logic                 w_has0;
    logic                 w_has1;

    // Lock comes from registered occupancy only; a same-cycle pop gives no credit.
    assign w_lock    = (LP_DEPTH - r_count) < LP_TWO_C;
    assign w_push_en = inRESET && !iEXCEPTION_EVENT && !w_lock;
    assign w_has0    = (r_count != '0);
    assign w_has1    = (r_count >= LP_TWO_C);
    // Slot 1 lands right behind slot 0 only when slot 0 is also written.
    assign w_wr1     = iPREVIOUS_0_INST_VALID ? (r_wptr + LP_ONE_P) : r_wptr;
    assign w_rd1     = r_rptr + LP_ONE_P;

    // Number of entries written and consumed this cycle.
    always_comb begin
        w_push_inc = '0;
        w_pop_inc  = '0;
        if (w_push_en) begin
            w_push_inc = P_DEPTH_N'(iPREVIOUS_0_INST_VALID) + P_DEPTH_N'(iPREVIOUS_1_INST_VALID);
        end
        if (!iNEXT_LOCK) begin
            w_pop_inc = w_has1 ? LP_TWO_P : P_DEPTH_N'(r_count);
        end
    end

    // Pointer and occupancy update: reset, then flush, then push/pop.
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (iEXCEPTION_EVENT) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + w_push_inc;
            r_rptr  <= r_rptr + w_pop_inc;
            r_count <= r_count + {1'b0, w_push_inc} - {1'b0, w_pop_inc};
        end
    end

    // Entry writes, slot 0 first, slot 1 at PC+4.
    always_ff @(posedge iCLOCK) begin
        if (w_push_en) begin
            if (iPREVIOUS_0_INST_VALID) begin
                r_inst[r_wptr]  <= iPREVIOUS_0_INST;
                r_flags[r_wptr] <= iPREVIOUS_0_MMU_FLAGS;
                r_pc[r_wptr]    <= iPREVIOUS_PC;
            end
            if (iPREVIOUS_1_INST_VALID) begin
                r_inst[w_wr1]  <= iPREVIOUS_1_INST;
                r_flags[w_wr1] <= iPREVIOUS_1_MMU_FLAGS;
                r_pc[w_wr1]    <= iPREVIOUS_PC + 32'd4;
            end
        end
    end

    // Output view of the two head entries; absent entries read as zero.
    always_comb begin
        oPREVIOUS_LOCK     = w_lock;
        oCOUNT             = r_count;
        oNEXT_0_INST_VALID = !iNEXT_LOCK && w_has0;
        oNEXT_1_INST_VALID = !iNEXT_LOCK && w_has1;
        oNEXT_0_INST       = w_has0 ? r_inst[r_rptr]  : 32'd0;
        oNEXT_0_MMU_FLAGS  = w_has0 ? r_flags[r_rptr] : 6'd0;
        oNEXT_0_PC         = w_has0 ? r_pc[r_rptr]    : 32'd0;
        oNEXT_1_INST       = w_has1 ? r_inst[w_rd1]   : 32'd0;
        oNEXT_1_MMU_FLAGS  = w_has1 ? r_flags[w_rd1]  : 6'd0;
        oNEXT_1_PC         = w_has1 ? r_pc[w_rd1]     : 32'd0;
    end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Testbench for fetch_inst_queue: queue-based scoreboard of expected entries.
module tb_fetch_inst_queue;

    logic        iCLOCK = 1'b0;
    logic        inRESET;
    logic        iEXCEPTION_EVENT;
    logic        iPREVIOUS_0_INST_VALID;
    logic [5:0]  iPREVIOUS_0_MMU_FLAGS;
    logic [31:0] iPREVIOUS_0_INST;
    logic        iPREVIOUS_1_INST_VALID;
    logic [5:0]  iPREVIOUS_1_MMU_FLAGS;
    logic [31:0] iPREVIOUS_1_INST;
    logic [31:0] iPREVIOUS_PC;
    logic        oPREVIOUS_LOCK;
    logic        oNEXT_0_INST_VALID;
    logic [5:0]  oNEXT_0_MMU_FLAGS;
    logic [31:0] oNEXT_0_INST;
    logic [31:0] oNEXT_0_PC;
    logic        oNEXT_1_INST_VALID;
    logic [5:0]  oNEXT_1_MMU_FLAGS;
    logic [31:0] oNEXT_1_INST;
    logic [31:0] oNEXT_1_PC;
    logic        iNEXT_LOCK;
    logic [3:0]  oCOUNT;

    fetch_inst_queue #(.P_DEPTH(8), .P_DEPTH_N(3)) dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET), .iEXCEPTION_EVENT(iEXCEPTION_EVENT),
        .iPREVIOUS_0_INST_VALID(iPREVIOUS_0_INST_VALID), .iPREVIOUS_0_MMU_FLAGS(iPREVIOUS_0_MMU_FLAGS),
        .iPREVIOUS_0_INST(iPREVIOUS_0_INST),
        .iPREVIOUS_1_INST_VALID(iPREVIOUS_1_INST_VALID), .iPREVIOUS_1_MMU_FLAGS(iPREVIOUS_1_MMU_FLAGS),
        .iPREVIOUS_1_INST(iPREVIOUS_1_INST), .iPREVIOUS_PC(iPREVIOUS_PC),
        .oPREVIOUS_LOCK(oPREVIOUS_LOCK),
        .oNEXT_0_INST_VALID(oNEXT_0_INST_VALID), .oNEXT_0_MMU_FLAGS(oNEXT_0_MMU_FLAGS),
        .oNEXT_0_INST(oNEXT_0_INST), .oNEXT_0_PC(oNEXT_0_PC),
        .oNEXT_1_INST_VALID(oNEXT_1_INST_VALID), .oNEXT_1_MMU_FLAGS(oNEXT_1_MMU_FLAGS),
        .oNEXT_1_INST(oNEXT_1_INST), .oNEXT_1_PC(oNEXT_1_PC),
        .iNEXT_LOCK(iNEXT_LOCK), .oCOUNT(oCOUNT)
    );

    always #5 iCLOCK = ~iCLOCK;

    typedef struct packed {
        logic [31:0] inst;
        logic [5:0]  fl;
        logic [31:0] pc;
    } ent_t;

    ent_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Compare outputs against the scoreboard, then advance the scoreboard by
    // the same edge's push/pop/flush/reset effects.
    task automatic tick();
        int   sz;
        bit   lk;
        ent_t e0;
        ent_t e1;
        @(negedge iCLOCK);
        sz = sb.size();
        if (chk_en) begin
            e0 = (sz >= 1) ? sb[0] : '0;
            e1 = (sz >= 2) ? sb[1] : '0;
            chk("count", 64'(oCOUNT), 64'(sz));
            chk("lock", 64'(oPREVIOUS_LOCK), 64'(sz >= 7));
            chk("v0", 64'(oNEXT_0_INST_VALID), 64'(!iNEXT_LOCK && sz >= 1));
            chk("v1", 64'(oNEXT_1_INST_VALID), 64'(!iNEXT_LOCK && sz >= 2));
            chk("inst0", 64'(oNEXT_0_INST), 64'(e0.inst));
            chk("fl0", 64'(oNEXT_0_MMU_FLAGS), 64'(e0.fl));
            chk("pc0", 64'(oNEXT_0_PC), 64'(e0.pc));
            chk("inst1", 64'(oNEXT_1_INST), 64'(e1.inst));
            chk("fl1", 64'(oNEXT_1_MMU_FLAGS), 64'(e1.fl));
            chk("pc1", 64'(oNEXT_1_PC), 64'(e1.pc));
        end
        if (!inRESET || iEXCEPTION_EVENT) begin
            sb.delete();
        end else begin
            lk = (sz >= 7);
            if (!iNEXT_LOCK) begin
                repeat (2) if (sb.size() > 0) void'(sb.pop_front());
            end
            if (!lk) begin
                if (iPREVIOUS_0_INST_VALID)
                    sb.push_back({iPREVIOUS_0_INST, iPREVIOUS_0_MMU_FLAGS, iPREVIOUS_PC});
                if (iPREVIOUS_1_INST_VALID)
                    sb.push_back({iPREVIOUS_1_INST, iPREVIOUS_1_MMU_FLAGS, iPREVIOUS_PC + 32'd4});
            end
        end
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic drive(input bit v0, input bit v1, input logic [31:0] i0,
                         input logic [31:0] i1, input logic [31:0] pc);
        iPREVIOUS_0_INST_VALID = v0;
        iPREVIOUS_1_INST_VALID = v1;
        iPREVIOUS_0_INST       = i0;
        iPREVIOUS_1_INST       = i1;
        iPREVIOUS_0_MMU_FLAGS  = i0[5:0] ^ 6'h15;
        iPREVIOUS_1_MMU_FLAGS  = i1[5:0] ^ 6'h2A;
        iPREVIOUS_PC           = pc;
    endtask

    initial begin
        inRESET = 1'b0;
        iEXCEPTION_EVENT = 1'b0;
        iNEXT_LOCK = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        #1;
        tick();
        chk_en = 1'b1;
        tick();
        inRESET = 1'b1;

        // Basic push of both slots, then drain.
        drive(1'b1, 1'b1, 32'hA000_0001, 32'hA000_0002, 32'h100);
        tick();
        chk("plan_cnt2", 64'(oCOUNT), 64'd2);
        chk("plan_pc1", 64'(oNEXT_1_PC), 64'h104);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        chk("plan_cnt0", 64'(oCOUNT), 64'd0);
        tick();

        // Fill while decoder stalled; fifth push must be ignored.
        iNEXT_LOCK = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 32'hB000_0000 + 32'(2*i), 32'hB000_0001 + 32'(2*i), 32'h1000 + 32'(8*i));
            tick();
            if (i == 2) chk("plan_cnt6", 64'(oCOUNT), 64'd6);
        end
        chk("plan_full", 64'(oCOUNT), 64'd8);
        chk("plan_lock", 64'(oPREVIOUS_LOCK), 64'd1);

        // Drain across the pointer wrap.
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        iNEXT_LOCK = 1'b0;
        repeat (5) tick();

        // Slot 1 only, then both slots while popping.
        drive(1'b0, 1'b1, 32'hC000_0000, 32'hC000_0001, 32'h200);
        tick();
        chk("plan_s1pc", 64'(oNEXT_0_PC), 64'h204);
        drive(1'b1, 1'b1, 32'hC000_0002, 32'hC000_0003, 32'h300);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        repeat (3) tick();

        // Flush with a same-cycle push at count 5.
        iNEXT_LOCK = 1'b1;
        drive(1'b1, 1'b1, 32'hD000_0000, 32'hD000_0001, 32'h400);
        tick();
        tick();
        drive(1'b1, 1'b0, 32'hD000_0004, 32'd0, 32'h410);
        tick();
        chk("plan_cnt5", 64'(oCOUNT), 64'd5);
        iEXCEPTION_EVENT = 1'b1;
        drive(1'b1, 1'b1, 32'hDEAD_0000, 32'hDEAD_0001, 32'h500);
        tick();
        iEXCEPTION_EVENT = 1'b0;
        chk("plan_flush", 64'(oCOUNT), 64'd0);
        iNEXT_LOCK = 1'b0;
        drive(1'b1, 1'b1, 32'hE000_0000, 32'hE000_0001, 32'h600);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        tick();

        // Reset mid-stream at count 3 with push/pop active.
        iNEXT_LOCK = 1'b1;
        drive(1'b1, 1'b1, 32'hF000_0000, 32'hF000_0001, 32'h700);
        tick();
        drive(1'b1, 1'b0, 32'hF000_0002, 32'd0, 32'h708);
        tick();
        chk("plan_cnt3", 64'(oCOUNT), 64'd3);
        iNEXT_LOCK = 1'b0;
        inRESET = 1'b0;
        drive(1'b1, 1'b1, 32'hF000_0010, 32'hF000_0011, 32'h710);
        tick();
        inRESET = 1'b1;
        chk("plan_rst", 64'(oCOUNT), 64'd0);
        drive(1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFFC);
        tick();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        tick();

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom);
            iNEXT_LOCK       = ($urandom_range(0, 3) == 0);
            iEXCEPTION_EVENT = ($urandom_range(0, 31) == 0);
            inRESET          = ($urandom_range(0, 63) != 0);
            tick();
        end
        inRESET = 1'b1;
        iEXCEPTION_EVENT = 1'b0;
        iNEXT_LOCK = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
